// File: rtl/mnist_result_scoreboard.sv
// mnist_result_scoreboard
//   Scores the classifier's predictions on-chip so board runs can report accuracy.
//   Ground-truth labels are queued when the pixel source starts an image. Each
//   prediction is paired in order with the oldest queued label. The block keeps
//   saturating total/hit counters, and on request computes floor(hits*100/total)
//   with a restoring divider that produces one quotient bit per cycle.
//
// Parameters
//   FIFO_DEPTH  label FIFO entries (power of 2, >= 2)
//   CNT_W       width of the total/hit counters
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   clear                 synchronous soft clear of counters, FIFO, flags and divider
//   label_in/label_valid  ground-truth label push; label_ready = FIFO not full
//   pred_in/pred_valid    classifier prediction (single-cycle pulse)
//   match_valid/match_hit one-cycle result of the pair just scored
//   total_cnt/hit_cnt     saturating scored / correct counters
//   report_req            start accuracy computation; busy while dividing
//   acc_pct/acc_valid     accuracy in percent, with a one-cycle update pulse
//   err_underflow         sticky: prediction arrived with no label queued
//   err_overflow          sticky: label dropped because the FIFO was full
//
// Configuration
//   MNIST_SCOREBOARD_PER_CLASS_EN adds class_sel / class_total / class_hits, backed by
//   per-label counters that are indexed by the popped label.
module mnist_result_scoreboard #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [3:0]       label_in,
  input  logic             label_valid,
  output logic             label_ready,
  input  logic [3:0]       pred_in,
  input  logic             pred_valid,
  output logic             match_valid,
  output logic             match_hit,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  input  logic             report_req,
  output logic             busy,
  output logic [6:0]       acc_pct,
  output logic             acc_valid,
  output logic             err_underflow,
  output logic             err_overflow
`ifdef MNIST_SCOREBOARD_PER_CLASS_EN
  ,
  input  logic [3:0]       class_sel,
  output logic [CNT_W-1:0] class_total,
  output logic [CNT_W-1:0] class_hits
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = CNT_W + 7;          // hit_cnt*100 fits in CNT_W+7 bits
  localparam int SW = $clog2(NW);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------- label FIFO and scoring ----------------
  logic [3:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fill;
  logic          fifo_full, fifo_empty, do_pop, do_push, pair_hit;
  logic [3:0]    head;

  assign fifo_full   = (fill == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty  = (fill == '0);
  assign label_ready = !fifo_full;
  assign head        = fifo_mem[rd_ptr];
  // An empty FIFO never forwards a same-cycle push to the pop side.
  assign do_pop      = pred_valid && !fifo_empty;
  // When full, a simultaneous pop frees the slot, so the push is accepted.
  assign do_push     = label_valid && (!fifo_full || do_pop);
  assign pair_hit    = (pred_in == head);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill          <= '0;
      match_valid   <= 1'b0;
      match_hit     <= 1'b0;
      total_cnt     <= '0;
      hit_cnt       <= '0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      if (do_push) begin
        fifo_mem[wr_ptr] <= label_in;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      fill <= fill + (AW+1)'(1);
      else if (do_pop && !do_push) fill <= fill - (AW+1)'(1);

      match_valid <= do_pop;
      match_hit   <= do_pop && pair_hit;
      if (do_pop) begin
        if (total_cnt != CNT_MAX)           total_cnt <= total_cnt + CNT_W'(1);
        if (pair_hit && hit_cnt != CNT_MAX) hit_cnt   <= hit_cnt + CNT_W'(1);
      end
      if (pred_valid && fifo_empty)              err_underflow <= 1'b1;
      if (label_valid && fifo_full && !do_pop)   err_overflow  <= 1'b1;
    end
  end

`ifdef MNIST_SCOREBOARD_PER_CLASS_EN
  // ---------------- per-label counters ----------------
  logic [CNT_W-1:0] cls_tot [10];
  logic [CNT_W-1:0] cls_hit [10];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int unsigned i = 0; i < 10; i++) begin
        cls_tot[i] <= '0;
        cls_hit[i] <= '0;
      end
    end else if (do_pop && head <= 4'd9) begin
      if (cls_tot[head] != CNT_MAX)             cls_tot[head] <= cls_tot[head] + CNT_W'(1);
      if (pair_hit && cls_hit[head] != CNT_MAX) cls_hit[head] <= cls_hit[head] + CNT_W'(1);
    end
  end

  assign class_total = (class_sel <= 4'd9) ? cls_tot[class_sel] : '0;
  assign class_hits  = (class_sel <= 4'd9) ? cls_hit[class_sel] : '0;
`endif

  // ---------------- accuracy divider ----------------
  typedef enum logic [1:0] {ACC_IDLE, ACC_DIV, ACC_DONE} acc_state_t;

  acc_state_t       acc_state;
  logic [NW-1:0]    div_num;    // dividend shifts out at the top, quotient shifts in at the bottom
  logic [CNT_W-1:0] div_den;
  logic [CNT_W-1:0] div_rem;
  logic [SW-1:0]    div_step;
  logic [CNT_W:0]   rem_shift, rem_diff;
  logic             q_bit;

  assign rem_shift = {div_rem, div_num[NW-1]};
  assign rem_diff  = rem_shift - {1'b0, div_den};
  // rem < den keeps rem_shift < 2*den, so the top bit of the difference is a pure borrow.
  assign q_bit     = !rem_diff[CNT_W];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      acc_state <= ACC_IDLE;
      busy      <= 1'b0;
      acc_valid <= 1'b0;
      acc_pct   <= '0;
      div_num   <= '0;
      div_den   <= '0;
      div_rem   <= '0;
      div_step  <= '0;
    end else begin
      acc_valid <= 1'b0;
      unique case (acc_state)
        ACC_IDLE: begin
          if (report_req) begin
            div_den  <= total_cnt;
            div_rem  <= '0;
            div_step <= SW'(NW - 1);
            if (total_cnt == '0) begin
              div_num   <= '0;
              acc_state <= ACC_DONE;
            end else begin
              div_num   <= NW'(hit_cnt) * NW'(100);
              acc_state <= ACC_DIV;
              busy      <= 1'b1;
            end
          end
        end
        ACC_DIV: begin
          div_rem <= q_bit ? rem_diff[CNT_W-1:0] : rem_shift[CNT_W-1:0];
          div_num <= {div_num[NW-2:0], q_bit};
          if (div_step == '0) begin
            acc_state <= ACC_DONE;
            busy      <= 1'b0;
          end else begin
            div_step <= div_step - SW'(1);
          end
        end
        ACC_DONE: begin
          acc_pct   <= div_num[6:0];
          acc_valid <= 1'b1;
          acc_state <= ACC_IDLE;
        end
        default: acc_state <= ACC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mnist_result_scoreboard.sv
// tb_mnist_result_scoreboard
//   Drives directed scenarios followed by random traffic. A queue-based reference
//   model predicts every output after each clock edge.
module tb_mnist_result_scoreboard;

  localparam int FD   = 4;
  localparam int CW   = 10;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, clear, label_valid, pred_valid, report_req;
  logic [3:0]    label_in, pred_in;
  logic          label_ready, match_valid, match_hit, busy, acc_valid;
  logic          err_underflow, err_overflow;
  logic [CW-1:0] total_cnt, hit_cnt;
  logic [6:0]    acc_pct;
`ifdef MNIST_SCOREBOARD_PER_CLASS_EN
  logic [3:0]    class_sel;
  logic [CW-1:0] class_total, class_hits;
`endif

  mnist_result_scoreboard #(.FIFO_DEPTH(FD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .label_in(label_in), .label_valid(label_valid), .label_ready(label_ready),
    .pred_in(pred_in), .pred_valid(pred_valid),
    .match_valid(match_valid), .match_hit(match_hit),
    .total_cnt(total_cnt), .hit_cnt(hit_cnt),
    .report_req(report_req), .busy(busy),
    .acc_pct(acc_pct), .acc_valid(acc_valid),
    .err_underflow(err_underflow), .err_overflow(err_overflow)
`ifdef MNIST_SCOREBOARD_PER_CLASS_EN
    , .class_sel(class_sel), .class_total(class_total), .class_hits(class_hits)
`endif
  );

  always #5 clk = ~clk;

  int total_checks = 0;
  int bad_checks   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int q[$];
  int m_tot, m_hit, m_und, m_ovf, m_acc;
  int m_act, m_k, m_tgt, m_snap;
  int m_ct[10];
  int m_ch[10];
  int sel_force = -1;

  function automatic void model_reset();
    q.delete();
    m_tot = 0; m_hit = 0; m_und = 0; m_ovf = 0; m_acc = 0;
    m_act = 0; m_k = 0; m_tgt = 0; m_snap = 0;
    for (int i = 0; i < 10; i++) begin m_ct[i] = 0; m_ch[i] = 0; end
  endfunction

  // One clock cycle: drive inputs, advance the model, compare after the edge.
  task automatic step(input int lv, input int lab, input int pv, input int pred,
                      input int rr, input int clr, input int rst);
    int  head;
    int  pop, full;
    int  e_mv, e_mh, e_av, e_busy;
    label_valid = (lv != 0);
    label_in    = 4'(lab);
    pred_valid  = (pv != 0);
    pred_in     = 4'(pred);
    report_req  = (rr != 0);
    clear       = (clr != 0);
    rst_n       = (rst == 0);
`ifdef MNIST_SCOREBOARD_PER_CLASS_EN
    class_sel   = (sel_force >= 0) ? 4'(sel_force) : 4'($urandom_range(0, 15));
`endif
    e_mv = 0; e_mh = 0; e_av = 0;
    if (rst != 0 || clr != 0) begin
      model_reset();
    end else begin
      full = (q.size() == FD);
      pop  = (pv != 0 && q.size() > 0);
      if (pv != 0 && q.size() == 0) m_und = 1;
      if (lv != 0 && full && !pop)  m_ovf = 1;
      // Accuracy: request latency is CNT_W+9 edges (2 when nothing was scored),
      // computed from the counters as they stood when the request was taken.
      if (m_act != 0) begin
        m_k++;
        if (m_k == m_tgt) begin
          e_av  = 1;
          m_acc = m_snap;
          m_act = 0;
        end
      end else if (rr != 0) begin
        m_act  = 1;
        m_k    = 1;
        m_tgt  = (m_tot == 0) ? 2 : CW + 9;
        m_snap = (m_tot == 0) ? 0 : (m_hit * 100) / m_tot;
      end
      if (pop) begin
        head = q.pop_front();
        e_mv = 1;
        e_mh = ((pred & 15) == head);
        if (m_tot < MAXC) m_tot++;
        if (e_mh != 0 && m_hit < MAXC) m_hit++;
        if (head <= 9) begin
          if (m_ct[head] < MAXC) m_ct[head]++;
          if (e_mh != 0 && m_ch[head] < MAXC) m_ch[head]++;
        end
      end
      if (lv != 0 && (!full || pop)) q.push_back(lab & 15);
    end
    e_busy = (m_act != 0 && m_tgt != 2 && m_k <= CW + 7);

    @(posedge clk);
    @(negedge clk);
    check("match_valid", match_valid, e_mv);
    check("match_hit", match_hit, e_mh);
    check("total_cnt", total_cnt, m_tot);
    check("hit_cnt", hit_cnt, m_hit);
    check("label_ready", label_ready, (q.size() < FD));
    check("err_underflow", err_underflow, m_und);
    check("err_overflow", err_overflow, m_ovf);
    check("busy", busy, e_busy);
    check("acc_valid", acc_valid, e_av);
    check("acc_pct", acc_pct, m_acc);
`ifdef MNIST_SCOREBOARD_PER_CLASS_EN
    check("class_total", class_total, (class_sel <= 9) ? m_ct[class_sel] : 0);
    check("class_hits", class_hits, (class_sel <= 9) ? m_ch[class_sel] : 0);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input int lab);
    step(1, lab, 0, 0, 0, 0, 0);
  endtask

  task automatic pred(input int p);
    step(0, 0, 1, p, 0, 0, 0);
  endtask

  task automatic do_clear();
    step(0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; label_valid = 1'b0; pred_valid = 1'b0;
    report_req = 1'b0; label_in = '0; pred_in = '0;
`ifdef MNIST_SCOREBOARD_PER_CLASS_EN
    class_sel = '0;
`endif
    model_reset();
    @(negedge clk);

    // Reset state
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    check("rst_label_ready", label_ready, 1);
    check("rst_total", total_cnt, 0);
    check("rst_acc_pct", acc_pct, 0);
    check("rst_busy", busy, 0);

    // Labels 7,2,1 with predictions 7,2,0 every 5 cycles, then a report
    push(7); push(2); push(1);
    pred(7); idle(4);
    pred(2); idle(4);
    pred(0); idle(4);
    check("s1_total", total_cnt, 3);
    check("s1_hit", hit_cnt, 2);
    step(0, 0, 0, 0, 1, 0, 0);
    idle(20);
    check("s1_acc_pct", acc_pct, 66);

    // Report with nothing scored
    do_clear();
    step(0, 0, 0, 0, 1, 0, 0);
    check("s2_busy", busy, 0);
    idle(3);
    check("s2_acc_pct", acc_pct, 0);

    // Overflow, then in-order scoring of the four accepted labels
    do_clear();
    for (int i = 1; i <= 5; i++) push(i);
    check("s3_ready", label_ready, 0);
    check("s3_overflow", err_overflow, 1);
    for (int i = 1; i <= 4; i++) pred(i);
    check("s3_hit", hit_cnt, 4);

    // Prediction with an empty FIFO
    pred(3);
    check("s4_underflow", err_underflow, 1);
    check("s4_match_valid", match_valid, 0);
    check("s4_total", total_cnt, 4);

    // Empty FIFO with push and pop together: push lands, pop is not served
    do_clear();
    step(1, 6, 1, 6, 0, 0, 0);
    check("s5_underflow", err_underflow, 1);

    // Full FIFO with simultaneous push and pop
    do_clear();
    push(5); push(6); push(7); push(8);
    step(1, 9, 1, 5, 0, 0, 0);
    check("s6_ready", label_ready, 0);
    check("s6_overflow", err_overflow, 0);
    check("s6_match_hit", match_hit, 1);

    // 1000 images, 950 correct
    do_clear();
    for (int i = 0; i < 1000; i++) begin
      int lab;
      lab = $urandom_range(0, 9);
      push(lab);
      pred((i % 20 == 7) ? (lab + 1) % 10 : lab);
    end
    check("s7_total", total_cnt, 1000);
    check("s7_hit", hit_cnt, 950);
    step(0, 0, 0, 0, 1, 0, 0);
    idle(20);
    check("s7_acc_pct", acc_pct, 95);

    // Clear while the divider is running
    step(0, 0, 0, 0, 1, 0, 0);
    idle(5);
    do_clear();
    check("s8_busy", busy, 0);
    check("s8_total", total_cnt, 0);
    idle(20);

`ifdef MNIST_SCOREBOARD_PER_CLASS_EN
    // Per-class counters: label 4 three times, two correct
    do_clear();
    sel_force = 4;
    push(4); pred(4); push(4); pred(4); push(4); pred(3);
    check("pc_total", class_total, 3);
    check("pc_hits", class_hits, 2);
    sel_force = -1;
`endif

    // Random traffic, including labels/predictions above 9, reports, clears and resets
    for (int i = 0; i < 1500; i++) begin
      int lv, pv, lab, pr, rr, clr, rst;
      lv  = ($urandom_range(0, 2) == 0);
      pv  = ($urandom_range(0, 2) == 0);
      lab = $urandom_range(0, 11);
      if ($urandom_range(0, 1) == 1 && q.size() > 0) pr = q[0];
      else pr = $urandom_range(0, 11);
      rr  = ($urandom_range(0, 30) == 0);
      clr = ($urandom_range(0, 300) == 0);
      rst = ($urandom_range(0, 400) == 0);
      step(lv, lab, pv, pr, rr, clr, rst);
    end
    idle(25);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
